window3x3_gen: RTL and testbench

// - Turns a raster pixel stream (row-major, 8-bit grey) into 3x3 neighbourhood windows.
// - Drives the nine window inputs and the qualifier of the downstream 3x3 edge-detect stage.
// - Holds two previous image rows in internal line buffers.
// - Emits one window per accepted pixel once row>=2 and col>=2: (W-2)*(H-2) windows per frame.

---
 rtl/window3x3_gen.sv | 146 ++++++++++++++
 tb/tb_window3x3_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/window3x3_gen.sv
// window3x3_gen: turns a row-major 8-bit pixel stream into 3x3 neighbourhood windows.
//   clk, rstn            clock, synchronous active-low reset
//   start                begin a frame (sampled only in IDLE)
//   pix_in, pix_valid    pixel stream; accepted when pix_valid & pix_ready
//   pix_ready            high while a frame is being received
//   win0..win8           window, rows top to bottom, leftmost column first in each row
//   win_valid            window outputs valid this cycle
//   win_col, win_row     window origin (top-left) column / row
//   frame_done           one-cycle pulse, coincident with the last window of the frame
module window3x3_gen #(
    parameter int H = 391,
    parameter int W = 317
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [7:0]  win0,
    output logic [7:0]  win1,
    output logic [7:0]  win2,
    output logic [7:0]  win3,
    output logic [7:0]  win4,
    output logic [7:0]  win5,
    output logic [7:0]  win6,
    output logic [7:0]  win7,
    output logic [7:0]  win8,
    output logic        win_valid,
    output logic [15:0] win_col,
    output logic [15:0] win_row,
    output logic        frame_done
);
    localparam int AW = (W > 1) ? $clog2(W) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state_q, state_d;
    logic [15:0] col_q, col_d, row_q, row_d;
    logic [15:0] win_col_q, win_col_d, win_row_q, win_row_d;
    logic [7:0]  win_q [9];
    logic [7:0]  win_d [9];
    logic        win_valid_q, win_valid_d;
    logic        pix_ready_q, pix_ready_d;
    logic        frame_done_q, frame_done_d;
    // Line buffers: lb1 holds row r-1, lb0 holds row r-2; contents are never reset.
    logic [7:0]  lb0 [W];
    logic [7:0]  lb1 [W];
    logic [AW-1:0] addr;
    logic [7:0]  lb0_rd, lb1_rd;
    logic        accept, last_col, last_row;

    assign accept   = pix_ready_q & pix_valid;
    assign addr     = col_q[AW-1:0];
    assign lb0_rd   = lb0[addr];
    assign lb1_rd   = lb1[addr];
    assign last_col = (col_q == 16'(W - 1));
    assign last_row = (row_q == 16'(H - 1));

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        win_d       = win_q;
        win_valid_d = 1'b0;
        win_col_d   = win_col_q;
        win_row_d   = win_row_q;
        case (state_q)
            IDLE: begin
                state_d = start ? RUN : IDLE;
                col_d   = start ? 16'd0 : col_q;
                row_d   = start ? 16'd0 : row_q;
            end
            RUN: begin
                if (accept) begin
                    col_d   = last_col ? 16'd0 : col_q + 16'd1;
                    row_d   = (last_col && !last_row) ? row_q + 16'd1 : row_q;
                    state_d = (last_col && last_row) ? DONE : RUN;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Columns 0 and 1 still shift the array so the window is primed by column 2,
        // but they never qualify a window (no wrap-around across rows).
        if (accept) begin
            for (int i = 0; i < 3; i++) begin
                win_d[3*i]   = win_q[3*i+1];
                win_d[3*i+1] = win_q[3*i+2];
            end
            win_d[2]    = lb0_rd;
            win_d[5]    = lb1_rd;
            win_d[8]    = pix_in;
            win_valid_d = (row_q >= 16'd2) && (col_q >= 16'd2);
            win_col_d   = win_valid_d ? col_q - 16'd2 : win_col_q;
            win_row_d   = win_valid_d ? row_q - 16'd2 : win_row_q;
        end
        pix_ready_d  = (state_d == RUN);
        frame_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '{default: '0};
            win_valid_q  <= 1'b0;
            win_col_q    <= '0;
            win_row_q    <= '0;
            pix_ready_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            win_col_q    <= win_col_d;
            win_row_q    <= win_row_d;
            pix_ready_q  <= pix_ready_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Read-before-write: the old lb1 entry ages into lb0 as the new pixel lands in lb1.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[addr] <= lb1_rd;
            lb1[addr] <= pix_in;
        end
    end

    assign pix_ready  = pix_ready_q;
    assign frame_done = frame_done_q;
    assign win_valid  = win_valid_q;
    assign win_col    = win_col_q;
    assign win_row    = win_row_q;
    assign win0       = win_q[0];
    assign win1       = win_q[1];
    assign win2       = win_q[2];
    assign win3       = win_q[3];
    assign win4       = win_q[4];
    assign win5       = win_q[5];
    assign win6       = win_q[6];
    assign win7       = win_q[7];
    assign win8       = win_q[8];
endmodule

// File: tb/tb_window3x3_gen.sv
// tb_window3x3_gen: checks window3x3_gen (5x4 and 3x3 images) against a frame-level window model.
module tb_window3x3_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn, start, pix_valid, sel;
    logic [7:0] pix_in;
    logic       ready_a, wv_a, fd_a, ready_b, wv_b, fd_b;
    logic [15:0] col_a, row_a, col_b, row_b;
    logic [7:0] wa [9];
    logic [7:0] wb [9];

    window3x3_gen #(.H(4), .W(5)) u_a (
        .clk(clk), .rstn(rstn), .start(start & ~sel), .pix_in(pix_in),
        .pix_valid(pix_valid & ~sel), .pix_ready(ready_a),
        .win0(wa[0]), .win1(wa[1]), .win2(wa[2]), .win3(wa[3]), .win4(wa[4]),
        .win5(wa[5]), .win6(wa[6]), .win7(wa[7]), .win8(wa[8]),
        .win_valid(wv_a), .win_col(col_a), .win_row(row_a), .frame_done(fd_a)
    );

    window3x3_gen #(.H(3), .W(3)) u_b (
        .clk(clk), .rstn(rstn), .start(start & sel), .pix_in(pix_in),
        .pix_valid(pix_valid & sel), .pix_ready(ready_b),
        .win0(wb[0]), .win1(wb[1]), .win2(wb[2]), .win3(wb[3]), .win4(wb[4]),
        .win5(wb[5]), .win6(wb[6]), .win7(wb[7]), .win8(wb[8]),
        .win_valid(wv_b), .win_col(col_b), .win_row(row_b), .frame_done(fd_b)
    );

    logic        rdy_o, wv_o, fd_o;
    logic [15:0] col_o, row_o;
    logic [71:0] win_o;
    always_comb begin
        rdy_o = sel ? ready_b : ready_a;
        wv_o  = sel ? wv_b : wv_a;
        fd_o  = sel ? fd_b : fd_a;
        col_o = sel ? col_b : col_a;
        row_o = sel ? row_b : row_a;
        win_o = '0;
        for (int i = 0; i < 9; i++) win_o[71-8*i -: 8] = sel ? wb[i] : wa[i];
    end

    typedef struct {
        logic [71:0] w;
        logic [15:0] c;
        logic [15:0] r;
    } win_t;
    win_t exp_q[$];
    win_t mon_e;
    logic [7:0] img [8][8];
    int errors = 0, checks = 0, n_win = 0, n_fd = 0, exp_n = 0;
    logic first_flag = 1'b0, prev_acc = 1'b0;
    logic [71:0] first_w, last_w;
    logic [15:0] last_c, last_r;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: every full 3x3 neighbourhood of the image, raster order of its bottom-right pixel.
    task automatic build(input int wv, input int hv, input int pat);
        win_t e;
        for (int r = 0; r < hv; r++)
            for (int c = 0; c < wv; c++)
                img[r][c] = (pat == 0) ? 8'(r*16 + c) : (pat == 1) ? 8'(r*wv + c + 1) : 8'($urandom);
        exp_n = 0;
        for (int r = 2; r < hv; r++)
            for (int c = 2; c < wv; c++) begin
                e.w = '0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++) e.w = {e.w[63:0], img[r-2+i][c-2+j]};
                e.c = 16'(c - 2);
                e.r = 16'(r - 2);
                exp_q.push_back(e);
                exp_n++;
            end
    endtask

    always @(negedge clk) begin
        if (wv_o) begin
            n_win++;
            check("win_after_accept", 72'(prev_acc), 72'(1));
            if (exp_q.size() == 0) check("extra_win", 72'(wv_o), 72'(0));
            else begin
                mon_e = exp_q.pop_front();
                check("win", win_o, mon_e.w);
                check("win_col", 72'(col_o), 72'(mon_e.c));
                check("win_row", 72'(row_o), 72'(mon_e.r));
            end
            if (first_flag) begin
                first_w    = win_o;
                first_flag = 1'b0;
            end
            last_w = win_o;
            last_c = col_o;
            last_r = row_o;
        end
        if (fd_o) begin
            n_fd++;
            check("fd_with_win", 72'(wv_o), 72'(1));
        end
        prev_acc = pix_valid & rdy_o;
    end

    // s: 0 -> 5x4 DUT, 1 -> 3x3 DUT; pvm: 0 always valid, 1 toggling, 2 random;
    // junk: drive pix_valid in IDLE and pulse start during RUN; abort: reset after that many accepts.
    task automatic send_frame(input int s, input int pat, input int pvm, input int junk, input int abort);
        int wv, hv, acc, t, base_w, base_fd;
        sel = s[0];
        wv = s ? 3 : 5;
        hv = s ? 3 : 4;
        build(wv, hv, pat);
        base_w = n_win;
        base_fd = n_fd;
        if (junk != 0) begin
            repeat (3) begin
                @(posedge clk); #1;
                pix_valid = 1'b1;
                pix_in = 8'($urandom);
                check("idle_ready", 72'(rdy_o), 72'(0));
            end
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
        start = 1'b1;
        first_flag = 1'b1;
        acc = 0;
        t = 0;
        while (acc < wv*hv && t < 2000) begin
            @(posedge clk); #1;
            t++;
            start = (junk != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            pix_valid = (pvm == 0) ? 1'b1 : (pvm == 1) ? 1'(t % 2) : ($urandom_range(0, 3) != 0);
            pix_in = pix_valid ? img[acc/wv][acc%wv] : 8'($urandom);
            if (pix_valid && rdy_o) begin
                acc++;
                if (abort != 0 && acc == abort) break;
            end
        end
        if (t >= 2000) check("accept_timeout", 72'(acc), 72'(wv*hv));
        @(posedge clk); #1;
        pix_valid = 1'b0;
        start = 1'b0;
        if (abort != 0) begin
            rstn = 1'b0;
            exp_q.delete();
            @(posedge clk); #1;
            rstn = 1'b1;
            @(negedge clk);
            check("rst_ctl", 72'({rdy_o, wv_o, fd_o, col_o, row_o}), 72'(0));
            check("rst_win", win_o, 72'(0));
            repeat (3) begin
                @(negedge clk);
                check("rst_no_ready", 72'(rdy_o), 72'(0));
            end
            return;
        end
        t = 0;
        while (!fd_o && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("done_seen", 72'(fd_o), 72'(1));
        @(negedge clk); #1;
        check("win_count", 72'(n_win - base_w), 72'(exp_n));
        check("fd_count", 72'(n_fd - base_fd), 72'(1));
        check("queue_empty", 72'(exp_q.size()), 72'(0));
    endtask

    task automatic t1_consts();
        check("t1_first", first_w, 72'h000102101112202122);
        check("t1_last", last_w, 72'h121314222324323334);
        check("t1_last_col", 72'(last_c), 72'(2));
        check("t1_last_row", 72'(last_r), 72'(1));
    endtask

    initial begin
        int b;
        rstn = 1'b0;
        start = 1'b0;
        pix_valid = 1'b0;
        pix_in = '0;
        sel = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("reset_ctl", 72'({rdy_o, wv_o, fd_o, col_o, row_o}), 72'(0));
        check("reset_win", win_o, 72'(0));

        send_frame(0, 0, 0, 0, 0);
        t1_consts();
        send_frame(0, 0, 1, 0, 0);
        t1_consts();
        send_frame(1, 1, 0, 0, 0);
        check("t3_win", first_w, 72'h010203040506070809);
        check("t3_col_row", 72'({last_c, last_r}), 72'(0));
        send_frame(0, 0, 0, 0, 7);
        send_frame(0, 0, 0, 0, 0);
        t1_consts();
        send_frame(0, 2, 2, 1, 0);
        b = n_win;
        send_frame(0, 0, 0, 0, 0);
        send_frame(0, 0, 0, 0, 0);
        t1_consts();
        check("t6_total", 72'(n_win - b), 72'(12));
        for (int k = 0; k < 6; k++)
            send_frame(k % 2, 2, int'($urandom_range(0, 2)), int'($urandom_range(0, 1)), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
